// File: rtl/nav_spreader_pkg.sv
// Shared types and sizing constants for the navigation-data spreader.
package nav_spreader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_RUN     = 2'd2
  } nav_state_t;

  localparam int unsigned DEF_CODE_LEN      = 32'd10230;
  localparam int unsigned DEF_CODES_PER_BIT = 32'd20;
  localparam int unsigned DEF_FIFO_DEPTH    = 32'd4;

  // Counter widths cover the largest legal parameter values.
  localparam int unsigned MAX_CODE_LEN      = 32'd16383;
  localparam int unsigned MAX_CODES_PER_BIT = 32'd31;
  localparam int unsigned CHIP_CNT_W        = $clog2(MAX_CODE_LEN + 32'd1);
  localparam int unsigned CODE_CNT_W        = $clog2(MAX_CODES_PER_BIT + 32'd1);
  localparam int unsigned BIT_CNT_W         = 32'd3;
  localparam int unsigned NAV_BYTE_W        = 32'd8;

endpackage

// File: rtl/nav_byte_fifo.sv
// Synchronous byte FIFO with show-ahead read data and registered full/empty flags.
module nav_byte_fifo
  import nav_spreader_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [NAV_BYTE_W-1:0] push_data,
  input  logic                  pop,
  output logic [NAV_BYTE_W-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 32'd1;

  logic [NAV_BYTE_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_nxt_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && !empty_r;

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_W'(DEPTH));
      empty_r <= (count_nxt_s == CNT_W'(0));
    end
  end

  // Storage array; contents need no reset because the flags gate every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = full_r;
  assign empty    = empty_r;

endmodule

// File: rtl/nav_spreader.sv
// Spreads queued navigation data bits over a PRN chip stream, one data bit per
// CODES_PER_BIT code periods, with epoch/bit strobes and a sticky underrun flag.
module nav_spreader
  import nav_spreader_pkg::*;
#(
  parameter int unsigned CODE_LEN      = DEF_CODE_LEN,
  parameter int unsigned CODES_PER_BIT = DEF_CODES_PER_BIT,
  parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  chip_in,
  input  logic                  chip_valid,
  input  logic [NAV_BYTE_W-1:0] nav_byte,
  input  logic                  nav_valid,
  output logic                  nav_ready,
  output logic                  spread_out,
  output logic                  spread_valid,
  output logic                  epoch_strobe,
  output logic                  bit_strobe,
  output logic                  underrun
);

  nav_state_t            state_r;
  logic [CHIP_CNT_W-1:0] chip_cnt_r;
  logic [CODE_CNT_W-1:0] code_cnt_r;
  logic [BIT_CNT_W-1:0]  bit_cnt_r;
  logic [NAV_BYTE_W-1:0] shifter_r;
  logic                  spread_out_r;
  logic                  spread_valid_r;
  logic                  epoch_strobe_r;
  logic                  bit_strobe_r;
  logic                  underrun_r;

  logic                  push_s;
  logic                  pop_s;
  logic [NAV_BYTE_W-1:0] fifo_data_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  chip_last_s;
  logic                  code_last_s;
  logic                  byte_last_s;
  logic                  advance_s;
  logic                  need_byte_s;

  assign chip_last_s = (chip_cnt_r == CHIP_CNT_W'(CODE_LEN - 32'd1));
  assign code_last_s = (code_cnt_r == CODE_CNT_W'(CODES_PER_BIT - 32'd1));
  assign byte_last_s = (bit_cnt_r == BIT_CNT_W'(7));
  assign advance_s   = (state_r == ST_RUN) && en && chip_valid;
  assign need_byte_s = advance_s && chip_last_s && code_last_s && byte_last_s;

  assign push_s = nav_valid && !fifo_full_s;

  // FIFO pop request: initial load in PRELOAD, then one per completed byte.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_PRELOAD: pop_s = en && !fifo_empty_s;
      ST_RUN:     pop_s = need_byte_s && !fifo_empty_s;
      default:    pop_s = 1'b0;
    endcase
  end

  nav_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (nav_byte),
    .pop       (pop_s),
    .pop_data  (fifo_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Control FSM, chip/code/bit counters, data shifter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      chip_cnt_r     <= '0;
      code_cnt_r     <= '0;
      bit_cnt_r      <= '0;
      shifter_r      <= '0;
      spread_out_r   <= 1'b0;
      spread_valid_r <= 1'b0;
      epoch_strobe_r <= 1'b0;
      bit_strobe_r   <= 1'b0;
      underrun_r     <= 1'b0;
    end else if (!en) begin
      // Losing enable abandons the current bit; queued bytes stay in the FIFO.
      state_r        <= ST_IDLE;
      chip_cnt_r     <= '0;
      code_cnt_r     <= '0;
      bit_cnt_r      <= '0;
      shifter_r      <= '0;
      spread_out_r   <= 1'b0;
      spread_valid_r <= 1'b0;
      epoch_strobe_r <= 1'b0;
      bit_strobe_r   <= 1'b0;
      underrun_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r        <= ST_PRELOAD;
          spread_valid_r <= 1'b0;
          epoch_strobe_r <= 1'b0;
          bit_strobe_r   <= 1'b0;
        end
        ST_PRELOAD: begin
          spread_valid_r <= 1'b0;
          epoch_strobe_r <= 1'b0;
          bit_strobe_r   <= 1'b0;
          if (!fifo_empty_s) begin
            shifter_r <= fifo_data_s;
            bit_cnt_r <= '0;
            state_r   <= ST_RUN;
          end else begin
            state_r <= ST_PRELOAD;
          end
        end
        ST_RUN: begin
          if (chip_valid) begin
            spread_out_r   <= chip_in ^ shifter_r[NAV_BYTE_W-1];
            spread_valid_r <= 1'b1;
            epoch_strobe_r <= (chip_cnt_r == CHIP_CNT_W'(0));
            bit_strobe_r   <= (chip_cnt_r == CHIP_CNT_W'(0)) && (code_cnt_r == CODE_CNT_W'(0));
            if (chip_last_s) begin
              chip_cnt_r <= '0;
              if (code_last_s) begin
                code_cnt_r <= '0;
                if (byte_last_s) begin
                  bit_cnt_r <= '0;
                  // An empty FIFO degrades to unmodulated PRN rather than stalling.
                  if (fifo_empty_s) begin
                    shifter_r  <= '0;
                    underrun_r <= 1'b1;
                  end else begin
                    shifter_r <= fifo_data_s;
                  end
                end else begin
                  bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                  shifter_r <= {shifter_r[NAV_BYTE_W-2:0], 1'b0};
                end
              end else begin
                code_cnt_r <= code_cnt_r + CODE_CNT_W'(1);
              end
            end else begin
              chip_cnt_r <= chip_cnt_r + CHIP_CNT_W'(1);
            end
          end else begin
            spread_valid_r <= 1'b0;
            epoch_strobe_r <= 1'b0;
            bit_strobe_r   <= 1'b0;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          spread_valid_r <= 1'b0;
          epoch_strobe_r <= 1'b0;
          bit_strobe_r   <= 1'b0;
        end
      endcase
    end
  end

  assign nav_ready    = !fifo_full_s;
  assign spread_out   = spread_out_r;
  assign spread_valid = spread_valid_r;
  assign epoch_strobe = epoch_strobe_r;
  assign bit_strobe   = bit_strobe_r;
  assign underrun     = underrun_r;

endmodule

// File: doc/nav_spreader.md
NAV_SPREADER -- requirements
Module: nav_spreader

Interface
REQ-001 Parameter CODE_LEN, default 10230, chips per PRN code period (range 2..16383).
REQ-002 Parameter CODES_PER_BIT, default 20, code periods per navigation data bit (range 1..31).
REQ-003 Parameter FIFO_DEPTH, default 4, nav byte FIFO entries (power of two, >=2).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  run enable from the code-generator output-enable.
REQ-007 chip_in  input  1  PRN chip from the upstream code generator.
REQ-008 chip_valid  input  1  chip_in is valid this cycle.
REQ-009 nav_byte  input  8  navigation data byte, MSB transmitted first.
REQ-010 nav_valid  input  1  nav_byte offered this cycle.
REQ-011 nav_ready  output  1  FIFO can accept a byte; equals not-full.
REQ-012 spread_out  output  1  chip XOR current data bit.
REQ-013 spread_valid  output  1  spread_out valid this cycle.
REQ-014 epoch_strobe  output  1  high with the first spread chip of every code period.
REQ-015 bit_strobe  output  1  high with the first spread chip of every data bit.
REQ-016 underrun  output  1  sticky: a data bit was needed while the FIFO was empty.

Function
REQ-017 States: IDLE, PRELOAD, RUN; IDLE when en=0; IDLE->PRELOAD on en=1.
REQ-018 PRELOAD: pop one byte into the 8-bit data shifter when the FIFO is non-empty, then RUN; chips arriving in IDLE/PRELOAD are dropped, no output.
REQ-019 RUN: each chip_valid produces spread_valid=1 next cycle with spread_out = chip_in XOR shifter[7]; fixed latency 1 cycle.
REQ-020 Chip counter 0..CODE_LEN-1 advances per accepted chip and wraps to 0; epoch_strobe accompanies the output of chip index 0.
REQ-021 Code counter 0..CODES_PER_BIT-1 advances on chip-counter wrap; bit_strobe accompanies chip index 0 when code counter is 0.
REQ-022 On code-counter wrap the shifter shifts left one bit; after the 8th bit the next byte is popped on that same cycle.
REQ-023 Pop with FIFO empty: shifter loads 0x00 (pure PRN output), underrun sets, RUN continues without chip loss.
REQ-024 underrun clears only on reset or en=0.
REQ-025 Push occurs when nav_valid and nav_ready; simultaneous push and pop both take effect; push while full is not accepted even if a pop occurs that cycle.
REQ-026 en falling mid-operation: next cycle IDLE, counters and shifter cleared, spread_valid=0, FIFO contents retained.
REQ-027 chip_valid gaps stall all counters; no output cycle without a corresponding chip.

Reset
REQ-028 On rst_n=0: state IDLE, counters 0, shifter 0, FIFO empty, nav_ready=1, spread_out=0, spread_valid=0, epoch_strobe=0, bit_strobe=0, underrun=0.
REQ-029 Reset has priority over en, chip_valid and nav_valid in the same cycle.

Structure
REQ-030 Shared package holds the state enum, default CODE_LEN/CODES_PER_BIT constants and the counter-width helper constants.
REQ-031 One sub-module, nav_byte_fifo (synchronous FIFO, push/pop/full/empty), instantiated once; counters, FSM and XOR stay in nav_spreader.

Verification
REQ-032 CODE_LEN=4, CODES_PER_BIT=2; push 0xA5, en=1, 64 continuous chips of 1 -> spread_out = NOT of bits 1,0,1,0,0,1,0,1 each held 8 chips; epoch_strobe every 4 chips; bit_strobe every 8.
REQ-033 Same params, FIFO empty at byte boundary after 0xFF -> chips 64+ equal chip_in unchanged, underrun=1 from the pop cycle, no dropped outputs.
REQ-034 Push 4 bytes with no pop -> nav_ready=0 after 4th; 5th nav_valid ignored; pop order matches push order.
REQ-035 chip_valid toggling 1/0 alternately -> spread_valid pulses one cycle after each valid chip; epoch spacing 4 valid chips, not 4 cycles.
REQ-036 en dropped at chip index 2 then raised -> spread_valid low within 1 cycle; restart with epoch_strobe on first new output; FIFO bytes preserved.
REQ-037 rst_n low mid-RUN with 3 bytes queued -> all outputs at reset values next cycle, nav_ready=1, FIFO empty.
